shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational shifter datapath between two requesters (req0 = integer ALU pipe, req1 = address/immediate generation unit).
- Round-robin arbitration with valid/ready handshakes on each requester port.
- The shifted result and the winning requester's ID are held in a single output register with backpressure.
- Sits beside the processor ALU; it is the only owner of the shifter instance.

Parameters:
n, 32, data width of operand and result
m, 5, shift-amount width (m = log2(n))

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  n  requester 0 operand
req0_shamt  input  m  requester 0 shift amount
req0_type  input  2  requester 0 shift type
req1_valid, req1_ready, req1_a, req1_shamt, req1_type  same as req0, for requester 1
res_valid  output  1  result register holds a result
res_ready  input  1  consumer takes the result this cycle
res_r  output  n  shifted result
res_id  output  1  requester that produced res_r (0/1)
grant_cnt0  output  16  accepted-op count, requester 0 (optional feature)
grant_cnt1  output  16  accepted-op count, requester 1 (optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - res_valid=0, res_r=0, res_id=0.
  - Round-robin pointer favours req0.
  - grant_cnt0 and grant_cnt1 = 0.
- Reset mid-operation: any held result is discarded and no handshake completes in that cycle. req*_ready is 0 while rst=1.
- Shift type encoding: 00 logical right; 01 left; 10 arithmetic right (sign of a[n-1] replicated); 11 pass a unchanged.
- Shift width rule: shamt is unsigned, 0..n-1. shamt=0 returns a for every type.
- Output register states: EMPTY (res_valid=0) and FULL (res_valid=1).
- can_accept = EMPTY, or (FULL and res_ready). Back-to-back throughput is one op per cycle.
- Grant rule:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester favoured by the pointer is granted.
  - The pointer moves to favour the other requester after every accepted op. It does not move when nothing is accepted.
- Ready signals:
  - reqX_ready = grantX & can_accept & ~rst.
  - Combinational from valids, pointer, res_valid and res_ready.
  - A requester must not make valid depend on ready. Once raised, valid and operands hold until ready.
- Accept: on a cycle with reqX_valid & reqX_ready, the register loads the shift of reqX's operands, res_id=X and res_valid=1. Latency is one cycle from accept to res_valid.
- Transitions:
  - FULL to EMPTY when res_ready=1 and no new accept.
  - FULL stays FULL with new data on simultaneous drain and accept.
  - FULL with res_ready=0: register, pointer and outputs hold. Both readys are 0.
- At most one reqX_ready is high in any cycle.

Optional Feature:
Macro SHIFT_ARB_STATS_EN.
- Defined:
  - grant_cnt0 and grant_cnt1 increment on each accept by requester 0 or 1 respectively.
  - Counters saturate at 16'hFFFF and clear on rst.
- Not defined: counter registers are not built and both ports are tied to 0. Port list is identical in both builds.

Test Plan:
- Single requester: req0 valid, a=32'h8000_0000, shamt=4, type=10, res_ready=1 -> req0_ready=1 that cycle. Next cycle res_valid=1, res_r=32'hF800_0000, res_id=0.
- Contention: both valid continuously with res_ready=1, req0 type=01 a=1 shamt=3, req1 type=00 a=32'hF0 shamt=4 -> grants alternate 0,1,0,1. res_r alternates 8 and 32'h0F. res_id alternates.
- Backpressure: result FULL, res_ready=0 for 3 cycles -> res_r, res_id and pointer stable, both readys 0. Raising res_ready with req1 valid -> drain and accept in the same cycle, res_valid stays 1.
- Boundaries: shamt=0 each type, a=32'hA5A5_A5A5 -> res_r=32'hA5A5_A5A5. shamt=31 type=00, a=32'h8000_0000 -> 1. type=11 -> a unchanged.
- Reset mid-operation: assert rst while FULL and both requesters valid -> next cycle res_valid=0, readys 0 during rst. After release, req0 is granted first.
- Stats (SHIFT_ARB_STATS_EN defined): 5 req0 accepts and 3 req1 accepts -> grant_cnt0=5, grant_cnt1=3. Without the macro both read 0.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Requester and result handshake bundle for shift_arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface shift_arbiter_if #(
  parameter int n = 32,
  parameter int m = 5
);
  logic         req0_valid;
  logic         req0_ready;
  logic [n-1:0] req0_a;
  logic [m-1:0] req0_shamt;
  logic [1:0]   req0_type;

  logic         req1_valid;
  logic         req1_ready;
  logic [n-1:0] req1_a;
  logic [m-1:0] req1_shamt;
  logic [1:0]   req1_type;

  logic         res_valid;
  logic         res_ready;
  logic [n-1:0] res_r;
  logic         res_id;

  modport master (
    output req0_valid, req0_a, req0_shamt, req0_type,
    input  req0_ready,
    output req1_valid, req1_a, req1_shamt, req1_type,
    input  req1_ready,
    input  res_valid, res_r, res_id,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_shamt, req0_type,
    output req0_ready,
    input  req1_valid, req1_a, req1_shamt, req1_type,
    output req1_ready,
    output res_valid, res_r, res_id,
    input  res_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin shared shifter with one registered result slot.
// SHIFT_ARB_STATS_EN builds saturating per-requester accept counters.
module shift_arbiter #(
  parameter int n = 32,
  parameter int m = 5
) (
  input  logic        clk,
  input  logic        rst,
  shift_arbiter_if.slave bus,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic         ptr_q;
  logic [n-1:0] r_q;
  logic         id_q;

  logic         grant0;
  logic         grant1;
  logic         can_accept;
  logic         acc0;
  logic         acc1;
  logic         acc;
  logic [n-1:0] sel_a;
  logic [m-1:0] sel_sh;
  logic [1:0]   sel_t;
  logic [n-1:0] shifted;

  function automatic logic [n-1:0] do_shift(
    input logic [n-1:0] a,
    input logic [m-1:0] sh,
    input logic [1:0]   t
  );
    logic [n-1:0] y;
    y = a;
    unique case (t)
      2'b00: y = a >> sh;
      2'b01: y = a << sh;
      2'b10: y = $unsigned($signed(a) >>> sh);
      2'b11: y = a;
    endcase
    return y;
  endfunction

  // ptr_q=0 favours req0, ptr_q=1 favours req1
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ptr_q);
  end

  assign can_accept = (state_q == EMPTY) | bus.res_ready;

  assign bus.req0_ready = grant0 & can_accept & ~rst;
  assign bus.req1_ready = grant1 & can_accept & ~rst;

  assign acc0 = bus.req0_valid & bus.req0_ready;
  assign acc1 = bus.req1_valid & bus.req1_ready;
  assign acc  = acc0 | acc1;

  always_comb begin
    sel_a  = bus.req0_a;
    sel_sh = bus.req0_shamt;
    sel_t  = bus.req0_type;
    if (grant1) begin
      sel_a  = bus.req1_a;
      sel_sh = bus.req1_shamt;
      sel_t  = bus.req1_type;
    end
  end

  assign shifted = do_shift(sel_a, sel_sh, sel_t);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (acc) state_d = FULL;
      FULL: begin
        if (acc) begin
          state_d = FULL;
        end else if (bus.res_ready) begin
          state_d = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 1'b0;
      r_q     <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        r_q   <= shifted;
        id_q  <= acc1;
        ptr_q <= acc0;
      end
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_r     = r_q;
  assign bus.res_id    = id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (acc0 && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (acc1 && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter.
// Counter expectations follow SHIFT_ARB_STATS_EN.
module tb_shift_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] gc0;
  logic [15:0] gc1;
  int          checks;
  int          errors;

  shift_arbiter_if #(.n(32), .m(5)) bus ();

  shift_arbiter #(.n(32), .m(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .grant_cnt0 (gc0),
    .grant_cnt1 (gc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rdy(string tag, logic e0, logic e1);
    #1;
    chk({tag, ".rdy0"}, {31'd0, bus.req0_ready}, {31'd0, e0});
    chk({tag, ".rdy1"}, {31'd0, bus.req1_ready}, {31'd0, e1});
  endtask

  task automatic chk_res(string tag, logic v, logic [31:0] r, logic id);
    chk({tag, ".valid"}, {31'd0, bus.res_valid}, {31'd0, v});
    chk({tag, ".r"}, bus.res_r, r);
    chk({tag, ".id"}, {31'd0, bus.res_id}, {31'd0, id});
  endtask

  task automatic chk_cnt(string tag, logic [15:0] e0, logic [15:0] e1);
`ifdef SHIFT_ARB_STATS_EN
    chk({tag, ".cnt0"}, {16'd0, gc0}, {16'd0, e0});
    chk({tag, ".cnt1"}, {16'd0, gc1}, {16'd0, e1});
`else
    chk({tag, ".cnt0"}, {16'd0, gc0}, 32'd0);
    chk({tag, ".cnt1"}, {16'd0, gc1}, 32'd0);
    if (e0 == 16'hFFFF && e1 == 16'hFFFF) $display("unreachable");
`endif
  endtask

  task automatic set0(logic v, logic [31:0] a, logic [4:0] sh, logic [1:0] t);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_shamt = sh;
    bus.req0_type  = t;
  endtask

  task automatic set1(logic v, logic [31:0] a, logic [4:0] sh, logic [1:0] t);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_shamt = sh;
    bus.req1_type  = t;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.res_ready = 1'b0;
    set0(1'b0, 32'd0, 5'd0, 2'b00);
    set1(1'b0, 32'd0, 5'd0, 2'b00);

    // reset state, readys held low under rst
    step();
    set0(1'b1, 32'h1, 5'd1, 2'b01);
    set1(1'b1, 32'h1, 5'd1, 2'b01);
    chk_rdy("rst", 1'b0, 1'b0);
    step();
    chk_res("rst", 1'b0, 32'd0, 1'b0);
    chk_cnt("rst", 16'd0, 16'd0);

    // single requester, arithmetic right
    rst = 1'b0;
    set1(1'b0, 32'd0, 5'd0, 2'b00);
    set0(1'b1, 32'h8000_0000, 5'd4, 2'b10);
    bus.res_ready = 1'b1;
    chk_rdy("single", 1'b1, 1'b0);
    step();
    set0(1'b0, 32'd0, 5'd0, 2'b00);
    chk_res("single", 1'b1, 32'hF800_0000, 1'b0);

    // req1 alone, shamt=31 logical right
    set1(1'b1, 32'h8000_0000, 5'd31, 2'b00);
    chk_rdy("sh31", 1'b0, 1'b1);
    step();
    set1(1'b0, 32'd0, 5'd0, 2'b00);
    chk_res("sh31", 1'b1, 32'h0000_0001, 1'b1);

    // contention: grants alternate starting with req0
    set0(1'b1, 32'h1, 5'd3, 2'b01);
    set1(1'b1, 32'hF0, 5'd4, 2'b00);
    for (int i = 0; i < 4; i++) begin
      chk_rdy("rr", (i % 2) == 0, (i % 2) == 1);
      step();
      chk_res("rr", 1'b1, (i % 2) == 0 ? 32'h8 : 32'h0F, (i % 2) == 1);
    end

    // backpressure: everything holds, both readys low
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("bp", 1'b0, 1'b0);
      step();
      chk_res("bp", 1'b1, 32'h0F, 1'b1);
    end
    // pointer must still favour req0
    bus.res_ready = 1'b1;
    chk_rdy("bp_rel", 1'b1, 1'b0);
    step();
    chk_res("bp_rel", 1'b1, 32'h8, 1'b0);

    // stall again, then drain and accept req1 together
    bus.res_ready = 1'b0;
    set0(1'b0, 32'd0, 5'd0, 2'b00);
    set1(1'b1, 32'h0000_0100, 5'd4, 2'b00);
    chk_rdy("bp2", 1'b0, 1'b0);
    step();
    chk_res("bp2", 1'b1, 32'h8, 1'b0);
    bus.res_ready = 1'b1;
    chk_rdy("drain_acc", 1'b0, 1'b1);
    step();
    set1(1'b0, 32'd0, 5'd0, 2'b00);
    chk_res("drain_acc", 1'b1, 32'h10, 1'b1);

    // drain with nothing pending empties the slot
    chk_rdy("idle", 1'b0, 1'b0);
    step();
    chk("drain.valid", {31'd0, bus.res_valid}, 32'd0);

    // shamt=0 returns a for every type
    for (int t = 0; t < 4; t++) begin
      set0(1'b1, 32'hA5A5_A5A5, 5'd0, 2'(t));
      chk_rdy("sh0", 1'b1, 1'b0);
      step();
      chk_res("sh0", 1'b1, 32'hA5A5_A5A5, 1'b0);
    end
    set0(1'b1, 32'h1234_5678, 5'd7, 2'b11);
    step();
    chk_res("pass", 1'b1, 32'h1234_5678, 1'b0);
    set0(1'b1, 32'h0000_00FF, 5'd31, 2'b01);
    step();
    chk_res("sll31", 1'b1, 32'h8000_0000, 1'b0);
    chk_cnt("mid", 16'd10, 16'd4);

    // reset while FULL and both requesting
    bus.res_ready = 1'b0;
    set1(1'b1, 32'hF0, 5'd4, 2'b00);
    set0(1'b1, 32'h1, 5'd3, 2'b01);
    rst = 1'b1;
    chk_rdy("rst_mid", 1'b0, 1'b0);
    step();
    chk_res("rst_mid", 1'b0, 32'd0, 1'b0);
    chk_cnt("rst_mid", 16'd0, 16'd0);

    // after release req0 wins first, then alternation
    rst = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk_rdy("post", (i % 2) == 0, (i % 2) == 1);
      step();
      chk_res("post", 1'b1, (i % 2) == 0 ? 32'h8 : 32'h0F, (i % 2) == 1);
    end
    set1(1'b0, 32'd0, 5'd0, 2'b00);
    step();
    step();
    set0(1'b0, 32'd0, 5'd0, 2'b00);
    chk_res("tail", 1'b1, 32'h8, 1'b0);
    chk_cnt("stats", 16'd5, 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
